// File: rtl/usb_tx_packet.sv
// -----------------------------------------------------------------------------
// usb_tx_packet
//
// Sends one USB-style packet on the DP/DM pair for each accepted start pulse.
// Packet layout on the wire:
//   SYNC (8 bits) -> PID (8 bits) -> [DATA (64 bits) -> CRC16 (16 bits)] -> EOP
// Bit stuffing (optional) and NRZI encoding are applied to every bit from the
// first SYNC bit through the last CRC bit. EOP is two SE0 cycles followed by
// one J cycle, during which o_done pulses.
//
// Build option:
//   USB_TX_STUFF_EN  defined   -> a 0 is inserted after six consecutive 1s.
//                    undefined -> no stuffing logic; packets are always
//                                 19 (token/handshake) or 99 (data) cycles.
//
// Ports:
//   i_clk       system clock, one line bit per cycle
//   i_rst       asynchronous active-high reset; aborts a packet immediately
//   i_start     one-cycle packet request, honoured only while idle
//   i_pid       4-bit packet ID, latched on an accepted start
//   i_has_data  1 = data packet (DATA + CRC), 0 = PID-only packet
//   i_data      64-bit payload, sent MSB first
//   o_dp/o_dm   registered line outputs (J = 1/0, K = 0/1, SE0 = 0/0)
//   o_busy      high from the cycle after start through the final J cycle
//   o_done      one-cycle pulse during the final J cycle of EOP
// -----------------------------------------------------------------------------
module usb_tx_packet (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_pid,
  input  logic        i_has_data,
  input  logic [63:0] i_data,
  output logic        o_dp,
  output logic        o_dm,
  output logic        o_busy,
  output logic        o_done
);

  // The state and bit counter name the NEXT bit to be put on the line. That
  // lets the accepting edge in IDLE already drive the first SYNC bit, so all
  // line outputs stay registered without adding a cycle of latency.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PID  = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_EOP  = 3'd5
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_next;
  logic [6:0]  r_bit_cnt;
  logic [6:0]  w_bit_cnt_next;
  logic [3:0]  r_pid;
  logic        r_has_data;
  logic [63:0] r_sreg;
  logic [15:0] r_crc;
  logic [15:0] w_crc_upd;
  logic        w_crc_fb;
  logic        r_level;
  logic        w_level_next;

  // Datapath control strobes from the FSM
  logic        w_load;
  logic        w_emit;
  logic        w_crc_init;
  logic        w_data_step;
  logic        w_crc_step;

  // Bit about to be encoded and the NRZI level it produces
  logic        w_tx_bit;
  logic        w_nrzi_level;
  logic        w_stuff;

  // Next values of the registered outputs
  logic        w_dp_next;
  logic        w_dm_next;
  logic        w_busy_next;
  logic        w_done_next;

  // ---------------------------------------------------------------------------
  // Bit stuffing
  // ---------------------------------------------------------------------------
`ifdef USB_TX_STUFF_EN
  logic [2:0] r_ones;

  // Ones are only counted on SYNC..CRC bits, and every SE0 or idle cycle
  // clears the counter, so a pending stuff in EOP can only be the one owed
  // to a run that ended on the last CRC bit.
  assign w_stuff = (r_state != ST_IDLE) && (r_ones == 3'd6);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ones <= 3'd0;
    end else if (w_emit) begin
      // a stuffed bit is a 0, so it clears the run like any real 0
      r_ones <= w_tx_bit ? (r_ones + 3'd1) : 3'd0;
    end else begin
      r_ones <= 3'd0;
    end
  end
`else
  assign w_stuff = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Source of the next unencoded bit
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tx_bit = 1'b0;
    if (!w_stuff) begin
      case (r_state)
        // IDLE only emits on an accepted start: SYNC bit 0, which is a 0
        ST_IDLE: w_tx_bit = 1'b0;
        // SYNC is seven 0s then a 1
        ST_SYNC: w_tx_bit = (r_bit_cnt == 7'd7);
        // low nibble is the PID LSB first, high nibble its complement
        ST_PID:  w_tx_bit = r_bit_cnt[2] ? ~r_pid[r_bit_cnt[1:0]]
                                         :  r_pid[r_bit_cnt[1:0]];
        ST_DATA: w_tx_bit = r_sreg[63];
        // complemented CRC register, MSB first
        ST_CRC:  w_tx_bit = ~r_crc[15];
        default: w_tx_bit = 1'b0;
      endcase
    end
  end

  // NRZI: a 0 toggles the line level, a 1 keeps it
  assign w_nrzi_level = w_tx_bit ? r_level : ~r_level;

  // Serial CRC16 step over the data bit currently leaving the shift register
  assign w_crc_fb  = r_crc[15] ^ r_sreg[63];
  assign w_crc_upd = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 16'h0000);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_load         = 1'b0;
    w_emit         = 1'b0;
    w_crc_init     = 1'b0;
    w_data_step    = 1'b0;
    w_crc_step     = 1'b0;
    w_level_next   = r_level;
    w_dp_next      = 1'b1;
    w_dm_next      = 1'b0;
    w_busy_next    = 1'b1;
    w_done_next    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy_next  = 1'b0;
        w_level_next = 1'b1;
        if (i_start) begin
          w_load         = 1'b1;
          w_emit         = 1'b1;
          w_busy_next    = 1'b1;
          w_state_next   = ST_SYNC;
          w_bit_cnt_next = 7'd1;
        end
      end

      ST_SYNC: begin
        w_emit = 1'b1;
        if (!w_stuff) begin
          if (r_bit_cnt == 7'd7) begin
            w_state_next   = ST_PID;
            w_bit_cnt_next = 7'd0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 7'd1;
          end
        end
      end

      ST_PID: begin
        w_emit = 1'b1;
        if (!w_stuff) begin
          if (r_bit_cnt == 7'd7) begin
            w_bit_cnt_next = 7'd0;
            if (r_has_data) begin
              w_state_next = ST_DATA;
              w_crc_init   = 1'b1;
            end else begin
              w_state_next = ST_EOP;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 7'd1;
          end
        end
      end

      ST_DATA: begin
        w_emit = 1'b1;
        if (!w_stuff) begin
          w_data_step = 1'b1;
          if (r_bit_cnt == 7'd63) begin
            w_state_next   = ST_CRC;
            w_bit_cnt_next = 7'd0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 7'd1;
          end
        end
      end

      ST_CRC: begin
        w_emit = 1'b1;
        if (!w_stuff) begin
          w_crc_step = 1'b1;
          if (r_bit_cnt == 7'd15) begin
            w_state_next   = ST_EOP;
            w_bit_cnt_next = 7'd0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 7'd1;
          end
        end
      end

      ST_EOP: begin
        if (w_stuff) begin
          // owed stuff bit for a run of ones that closed the CRC field
          w_emit = 1'b1;
        end else if (r_bit_cnt < 7'd2) begin
          w_dp_next      = 1'b0;
          w_dm_next      = 1'b0;
          w_bit_cnt_next = r_bit_cnt + 7'd1;
        end else if (r_bit_cnt == 7'd2) begin
          w_done_next    = 1'b1;
          w_level_next   = 1'b1;
          w_bit_cnt_next = 7'd3;
        end else begin
          // the final J cycle is still part of the packet; leave here so that
          // a start is first accepted in the cycle after done
          w_busy_next    = 1'b0;
          w_state_next   = ST_IDLE;
          w_bit_cnt_next = 7'd0;
        end
      end

      default: begin
        w_busy_next    = 1'b0;
        w_state_next   = ST_IDLE;
        w_bit_cnt_next = 7'd0;
      end
    endcase

    if (w_emit) begin
      w_level_next = w_nrzi_level;
      w_dp_next    = w_nrzi_level;
      w_dm_next    = ~w_nrzi_level;
    end
  end

  // ---------------------------------------------------------------------------
  // State, datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 7'd0;
      r_level    <= 1'b1;
      o_dp       <= 1'b1;
      o_dm       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_level    <= w_level_next;
      o_dp       <= w_dp_next;
      o_dm       <= w_dm_next;
      o_busy     <= w_busy_next;
      o_done     <= w_done_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pid      <= 4'd0;
      r_has_data <= 1'b0;
      r_sreg     <= 64'd0;
    end else if (w_load) begin
      r_pid      <= i_pid;
      r_has_data <= i_has_data;
      r_sreg     <= i_data;
    end else if (w_data_step) begin
      r_sreg     <= {r_sreg[62:0], 1'b0};
    end
  end

  // The CRC register holds during stuffed bits because the step strobes are
  // only raised on real field bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc <= CRC_INIT;
    end else if (w_crc_init) begin
      r_crc <= CRC_INIT;
    end else if (w_data_step) begin
      r_crc <= w_crc_upd;
    end else if (w_crc_step) begin
      r_crc <= {r_crc[14:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_usb_tx_packet.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_packet
//
// Drives directed and random packets into usb_tx_packet and compares every
// line cycle against a reference built from the packet format: bit list ->
// stuffing -> NRZI -> EOP. The captured DP stream of each complete packet is
// also decoded back (NRZI decode + unstuff) and its PID and payload checked.
// -----------------------------------------------------------------------------
module tb_usb_tx_packet;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  pid;
  logic        has_data;
  logic [63:0] data;
  logic        dp;
  logic        dm;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;

  // expected {dp, dm, busy, done} for cycles 1..N of the current packet
  logic [3:0] exp_q[$];
  int         exp_stuffed;

  always #5 clk = ~clk;

  usb_tx_packet dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_pid      (pid),
    .i_has_data (has_data),
    .i_data     (data),
    .o_dp       (dp),
    .o_dm       (dm),
    .o_busy     (busy),
    .o_done     (done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CRC as polynomial remainder: (M(x)*x^16 + FFFF*x^64) mod (x^16+x^15+x^2+1)
  function automatic logic [15:0] crc_ref(input logic [63:0] d);
    logic [79:0] v;
    v = {d, 16'h0000} ^ {16'hFFFF, 64'h0};
    for (int i = 79; i >= 16; i--) begin
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h18005;
    end
    return v[15:0];
  endfunction

  task automatic build_expected(input logic [3:0] p, input logic hd, input logic [63:0] d);
    bit         raw[$];
    bit         txb[$];
    int         ones;
    bit         lvl;
    logic [15:0] c;
    exp_q.delete();
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int i = 0; i < 4; i++) raw.push_back(p[i]);
    for (int i = 0; i < 4; i++) raw.push_back(!p[i]);
    if (hd) begin
      for (int i = 63; i >= 0; i--) raw.push_back(d[i]);
      c = ~crc_ref(d);
      for (int i = 15; i >= 0; i--) raw.push_back(c[i]);
    end
    ones = 0;
    foreach (raw[i]) begin
      txb.push_back(raw[i]);
`ifdef USB_TX_STUFF_EN
      if (raw[i]) ones++;
      else ones = 0;
      if (ones == 6) begin
        txb.push_back(1'b0);
        ones = 0;
      end
`endif
    end
    exp_stuffed = txb.size() - raw.size();
    lvl = 1'b1;
    foreach (txb[i]) begin
      if (!txb[i]) lvl = !lvl;
      exp_q.push_back({lvl, !lvl, 1'b1, 1'b0});
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1011);
  endtask

  // Called at a negedge in a cycle where the DUT may accept start.
  // poke_cycle: cycle in which a stray start is pulsed (0 = none, -1 = done cycle)
  // rst_cycle : cycle after which reset is asserted (0 = none)
  task automatic run_packet(input string name, input logic [3:0] p, input logic hd,
                            input logic [63:0] d, input int poke_cycle, input int rst_cycle);
    int   n;
    int   poke;
    int   done_cnt;
    int   done_cyc;
    bit   aborted;
    bit   line[$];
    bit   dec[$];
    bit   prev;
    bit   b;
    int   ones;
    bit   skip;
    logic [7:0]  pid_byte;
    logic [63:0] got_data;

    build_expected(p, hd, d);
    n        = exp_q.size();
    poke     = (poke_cycle < 0) ? n : poke_cycle;
    done_cnt = 0;
    done_cyc = 0;
    aborted  = 1'b0;

    pid      = p;
    has_data = hd;
    data     = d;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // scramble the inputs: the DUT must use its latched copies
    pid      = 4'($urandom);
    has_data = 1'($urandom);
    data     = {$urandom, $urandom};

    for (int c = 1; c <= n + 1; c++) begin
      check_val($sformatf("%s.c%0d", name, c), {dp, dm, busy, done},
                (c <= n) ? exp_q[c-1] : 4'b1000);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c <= n - 3) line.push_back(dp);
      if (c == rst_cycle) begin
        rst = 1'b1;
        @(negedge clk);
        check_val($sformatf("%s.rst_line", name), {dp, dm, busy, done}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        check_val($sformatf("%s.rst_idle", name), {dp, dm, busy, done}, 4'b1000);
        aborted = 1'b1;
        break;
      end
      if (c == n + 1) break;
      if (c == poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    if (!aborted) begin
      check_val($sformatf("%s.done_cnt", name), done_cnt, 1);
      check_val($sformatf("%s.done_cyc", name), done_cyc, (hd ? 99 : 19) + exp_stuffed);
      // NRZI decode of the captured line, then remove stuffed bits
      prev = 1'b1;
      ones = 0;
      skip = 1'b0;
      foreach (line[i]) begin
        b    = (line[i] == prev);
        prev = line[i];
`ifdef USB_TX_STUFF_EN
        if (skip) begin
          skip = 1'b0;
          ones = 0;
          continue;
        end
        if (b) ones++;
        else ones = 0;
        if (ones == 6) skip = 1'b1;
`endif
        dec.push_back(b);
      end
      check_val($sformatf("%s.dec_len", name), dec.size(), hd ? 96 : 16);
      if (dec.size() >= 16) begin
        for (int i = 0; i < 8; i++) pid_byte[i] = dec[8 + i];
        check_val($sformatf("%s.dec_pid", name), pid_byte, {~p, p});
      end
      if (hd && dec.size() >= 80) begin
        for (int i = 0; i < 64; i++) got_data[63 - i] = dec[16 + i];
        check_val($sformatf("%s.dec_data", name), got_data, d);
      end
    end
    $display("pkt %s pid=%h has_data=%0d data=%h cycles=%0d stuffed=%0d aborted=%0d",
             name, p, hd, d, n, exp_stuffed, aborted);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    rst      = 1'b1;
    start    = 1'b0;
    pid      = 4'd0;
    has_data = 1'b0;
    data     = 64'd0;
    repeat (2) @(negedge clk);
    check_val("reset", {dp, dm, busy, done}, 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle", {dp, dm, busy, done}, 4'b1000);

    // ACK, immediately followed by back-to-back packets
    run_packet("ack", 4'b0010, 1'b0, 64'd0, 0, 0);
    run_packet("allones", 4'b0011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
`ifndef USB_TX_STUFF_EN
    check_val("allones_len", exp_q.size(), 99);
`endif
    run_packet("msbfirst", 4'b0011, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 0);
    run_packet("poke5", 4'b1011, 1'b1, 64'hDEAD_BEEF_0F0F_7E7E, 5, 0);
    run_packet("pokedone", 4'b1001, 1'b0, 64'd0, -1, 0);
    run_packet("abort40", 4'b0011, 1'b1, 64'hFFFF_0000_FFFF_0000, 0, 40);
    run_packet("fresh", 4'b1011, 1'b1, 64'hFEDC_BA98_7654_3210, 0, 0);

    for (int k = 0; k < 10; k++) begin
      rd = {$urandom, $urandom};
      if (k % 2 == 0) rd = rd | {$urandom, $urandom} | {$urandom, $urandom};
      run_packet($sformatf("rnd%0d", k), 4'($urandom), 1'($urandom), rd,
                 ((k % 3) == 0) ? 2 + int'($urandom_range(0, 14)) : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_packet.md
# usb_tx_packet

Serialises one USB-style packet onto the DP/DM line pair: SYNC, PID, an optional 64-bit data field with CRC16, then EOP. Bit stuffing and NRZI encoding are applied on the way out. It is the transmit-side counterpart of the receive datapath (NRZI decode, unstuff, sync/PID check, CRC16 check). It is driven by the top-level protocol FSM, one packet per `start` pulse.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  system clock; one line bit per cycle.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `pid`  in  4  packet ID nibble; latched on accepted `start`.
- `has_data`  in  1  1 = data packet (DATA + CRC fields); 0 = token/handshake (PID only); latched with `pid`.
- `data`  in  64  payload; latched with `pid`.
- `DP`  out  1  line D+ (registered).
- `DM`  out  1  line D− (registered).
- `busy`  out  1  high from the cycle after an accepted `start` through the final J cycle of EOP.
- `done`  out  1  one-cycle pulse during the final EOP J cycle.

## Operation
- States: IDLE → SYNC → PID → (DATA → CRC if `has_data`) → EOP → IDLE.
- IDLE
  - Line at J (DP=1, DM=0).
  - `start`=1 latches `pid`, `has_data` and `data`, then moves to SYNC.
  - `start` in any other state is ignored.
- SYNC: 8 bits, sent in order 0,0,0,0,0,0,0,1.
- PID: byte {~pid, pid}, sent LSB first: pid[0..3], then ~pid[0..3].
- DATA: 64 bits, sent MSB first (`data[63]` first).
- CRC
  - Polynomial 0x8005, register initialised to 16'hFFFF at DATA entry.
  - Computed over the 64 unstuffed data bits.
  - Ones complement of the register is sent, MSB first.
- Bit counter (7 bits) counts field bits and excludes stuffed bits. The field ends when the count reaches 8/8/64/16.
- Bit stuffing
  - A 3-bit ones counter runs over the unencoded stream from the first SYNC bit through the last CRC bit.
  - After six consecutive 1s, one 0 is inserted. The ones counter clears, and the bit counter, data shift register and CRC hold for that cycle.
  - Any transmitted 0 (stuffed or real) clears the counter.
  - A run ending on the last CRC bit still gets its stuffed 0 before EOP.
- NRZI
  - A `level` register resets to 1.
  - A 0 bit toggles `level`; a 1 bit holds it.
  - DP=`level`, DM=~`level`.
- EOP
  - Two cycles of SE0 (DP=0, DM=0), then one cycle of J (DP=1, DM=0) with `done`=1.
  - Then IDLE; `level` is re-initialised to 1.

## Timing
- Reset values: DP=1, DM=0, `busy`=0, `done`=0. State is IDLE, all counters are 0, `level`=1, CRC=16'hFFFF.
- `rst` asserted mid-packet aborts at once: line returns to J, and no `done` is issued.
- `start` sampled at edge 0:
  - first SYNC bit is on DP/DM in cycle 1;
  - `busy`=1 from cycle 1.
- Non-data packet with no stuffing:
  - SYNC occupies cycles 1–8, PID 9–16, SE0 17–18;
  - J+`done` in cycle 19;
  - `busy`=0 and IDLE in cycle 20.
- Data packet total length is 99 cycles plus one cycle per stuffed bit.
- A new `start` is accepted at the earliest in the cycle after `done`.
- All outputs are registered; no combinational path from inputs to DP/DM.

## Configuration
- `USB_TX_STUFF_EN`
  - Defined: bit stuffing as described above.
  - Undefined: the stuffing logic is removed, no bits are inserted, and packet length is exactly 19 (non-data) or 99 (data) cycles.
- All other behaviour is identical in both builds.

## Test plan
- ACK: `pid`=4'b0010, `has_data`=0.
  - Decoded bits: 00000001 01001011.
  - Line: KJKJKJKK, then the NRZI of the PID.
  - SE0 in cycles 17–18; `done` in cycle 19; `busy` falls in cycle 20.
- DATA0 all-ones: `pid`=4'b0011, `data`=64'hFFFF_FFFF_FFFF_FFFF.
  - Decoded stream never has more than six consecutive 1s.
  - 11 stuffed 0s inside/after the data field (first after data bit 4).
  - After unstuffing, the CRC field equals the reference-model CRC.
- Data `data`=64'h0123_4567_89AB_CDEF, `pid`=4'b0011.
  - Decoded field is MSB first.
  - Feeding DP into the receive datapath yields `msg_out`=64'h0123_4567_89AB_CDEF with `msg_ok`=1.
- `start` pulsed in cycle 5 of an active packet: ignored. The packet is unchanged, and only one `done` is issued.
- `rst` asserted in cycle 40 of a data packet.
  - Next cycle: DP=1, DM=0, `busy`=0, `done`=0.
  - A fresh `start` afterwards produces a correct, complete packet.
- Build without `USB_TX_STUFF_EN`, all-ones data: exactly 64 consecutive data-bit cycles with no inserted 0, and `done` in cycle 99.
